branch_resolve_unit: RTL and testbench

Parametrised EX-stage branch resolver for the RISC-V PPU. It evaluates all six conditional branches plus JAL/JALR on full XLEN operands, compares the outcome against the fetch-time prediction, and issues a registered one-cycle redirect. It also maintains an optional 2-bit bimodal branch history table (BHT) that supplies IF-stage predictions.

---
 rtl/branch_resolve_unit.sv | 144 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: evaluates BEQ..BGEU/JAL/JALR, issues a registered one-cycle
// redirect on mispredict or jump, and squashes one wrong-path instruction. BHT enabled by BRU_BHT_EN.
module branch_resolve_unit #(
   parameter int          XLEN      = 32,
   parameter int          BHT_DEPTH = 64,
   parameter logic [1:0]  CNT_INIT  = 2'b01,
   parameter int          MCNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [XLEN-1:0]   if_pc_i,
   output logic              pred_taken_o,
   input  logic              ex_valid_i,
   input  logic [6:0]        ex_opcode_i,
   input  logic [2:0]        ex_funct3_i,
   input  logic [XLEN-1:0]   ex_rs1_i,
   input  logic [XLEN-1:0]   ex_rs2_i,
   input  logic [XLEN-1:0]   ex_pc_i,
   input  logic [XLEN-1:0]   ex_imm_i,
   input  logic              ex_pred_taken_i,
   input  logic              stall_i,
   output logic              redirect_o,
   output logic [XLEN-1:0]   redirect_pc_o,
   output logic              br_taken_o,
   output logic [MCNT_W-1:0] mispredict_cnt_o
);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic              redirect_q, redirect_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
   logic              br_taken_q, br_taken_d;
   logic [MCNT_W-1:0] mcnt_q, mcnt_d;
   logic              shadow_q, shadow_d;

   logic              eval, is_br, br_legal, is_jump, taken, bht_we;
   logic [XLEN-1:0]   br_target, jalr_target, fall_through, jump_target;

   assign eval         = ex_valid_i & ~stall_i & ~shadow_q;
   assign is_br        = (ex_opcode_i == OP_BRANCH);
   assign br_legal     = is_br & (ex_funct3_i[2:1] != 2'b01);
   assign is_jump      = (ex_opcode_i == OP_JAL) | (ex_opcode_i == OP_JALR);
   assign br_target    = ex_pc_i + ex_imm_i;
   assign jalr_target  = (ex_rs1_i + ex_imm_i) & ~XLEN'(1);
   assign fall_through = ex_pc_i + XLEN'(4);
   assign jump_target  = (ex_opcode_i == OP_JALR) ? jalr_target : br_target;
   assign bht_we       = eval & br_legal;

   always_comb begin
      taken = 1'b0;
      case (ex_funct3_i)
         3'b000:  taken = (ex_rs1_i == ex_rs2_i);
         3'b001:  taken = (ex_rs1_i != ex_rs2_i);
         3'b100:  taken = ($signed(ex_rs1_i) <  $signed(ex_rs2_i));
         3'b101:  taken = ($signed(ex_rs1_i) >= $signed(ex_rs2_i));
         3'b110:  taken = (ex_rs1_i <  ex_rs2_i);
         3'b111:  taken = (ex_rs1_i >= ex_rs2_i);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      br_taken_d    = br_taken_q;
      mcnt_d        = mcnt_q;
      // Shadow survives stalls so the squashed slot is the next instruction that actually issues.
      shadow_d      = stall_i ? shadow_q : 1'b0;
      if (eval && br_legal) begin
         br_taken_d = taken;
         if (taken != ex_pred_taken_i) begin
            redirect_d    = 1'b1;
            redirect_pc_d = taken ? br_target : fall_through;
            shadow_d      = 1'b1;
            if (~&mcnt_q)
               mcnt_d = mcnt_q + MCNT_W'(1);
         end
      end else if (eval && is_jump) begin
         redirect_d    = 1'b1;
         redirect_pc_d = jump_target;
         br_taken_d    = 1'b1;
         shadow_d      = 1'b1;
      end else if (eval && is_br) begin
         br_taken_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         br_taken_q    <= 1'b0;
         mcnt_q        <= '0;
         shadow_q      <= 1'b0;
      end else begin
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         br_taken_q    <= br_taken_d;
         mcnt_q        <= mcnt_d;
         shadow_q      <= shadow_d;
      end
   end

   assign redirect_o       = redirect_q;
   assign redirect_pc_o    = redirect_pc_q;
   assign br_taken_o       = br_taken_q;
   assign mispredict_cnt_o = mcnt_q;

`ifdef BRU_BHT_EN
   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]       bht_q [BHT_DEPTH];
   logic [IDX_W-1:0] rd_idx, wr_idx;

   assign rd_idx = if_pc_i[IDX_W+1:2];
   assign wr_idx = ex_pc_i[IDX_W+1:2];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < BHT_DEPTH; i++)
            bht_q[i] <= CNT_INIT;
      end else if (bht_we) begin
         if (taken && bht_q[wr_idx] != 2'b11)
            bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
         else if (!taken && bht_q[wr_idx] != 2'b00)
            bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
      end
   end

   // Read is from the registered array, so a same-index update shows the old counter.
   assign pred_taken_o = bht_q[rd_idx][1];

   logic unused_ok;
   assign unused_ok = ^{if_pc_i, ex_pc_i};
`else
   assign pred_taken_o = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{if_pc_i, CNT_INIT, BHT_DEPTH[0], bht_we};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: resolution, redirect/shadow, stall, saturation, reset, BHT.
module tb_branch_resolve_unit;

   localparam int XLEN = 32;
   localparam int MW   = 3;

   logic            clk_i = 1'b0;
   logic            reset_i = 1'b1;
   logic [XLEN-1:0] if_pc_i = '0;
   logic            pred_taken_o;
   logic            ex_valid_i = 1'b0;
   logic [6:0]      ex_opcode_i = '0;
   logic [2:0]      ex_funct3_i = '0;
   logic [XLEN-1:0] ex_rs1_i = '0, ex_rs2_i = '0, ex_pc_i = '0, ex_imm_i = '0;
   logic            ex_pred_taken_i = 1'b0;
   logic            stall_i = 1'b0;
   logic            redirect_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            br_taken_o;
   logic [MW-1:0]   mispredict_cnt_o;

   int checks = 0;
   int errors = 0;

   branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(64), .CNT_INIT(2'b01), .MCNT_W(MW)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .if_pc_i(if_pc_i), .pred_taken_o(pred_taken_o),
      .ex_valid_i(ex_valid_i), .ex_opcode_i(ex_opcode_i), .ex_funct3_i(ex_funct3_i),
      .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i),
      .ex_pred_taken_i(ex_pred_taken_i), .stall_i(stall_i), .redirect_o(redirect_o),
      .redirect_pc_o(redirect_pc_o), .br_taken_o(br_taken_o), .mispredict_cnt_o(mispredict_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ex(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred);
      ex_valid_i = 1'b1; ex_opcode_i = op; ex_funct3_i = f3; ex_rs1_i = rs1; ex_rs2_i = rs2;
      ex_pc_i = pc; ex_imm_i = imm; ex_pred_taken_i = pred;
   endtask

   task automatic idle();
      ex_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL rst_redirect got %0h exp 0", redirect_o); end
      checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc got %0h exp 0", redirect_pc_o); end
      checks++; if (br_taken_o !== 1'b0) begin errors++; $display("FAIL rst_br_taken got %0h exp 0", br_taken_o); end
      checks++; if (mispredict_cnt_o !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", mispredict_cnt_o); end
      checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL rst_pred got %0h exp 0", pred_taken_o); end
      step(); reset_i = 1'b0; step();
   endtask

   task automatic test_beq();
      set_ex(7'b1100011, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
      step();
      checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL beq_redirect got %0h exp 1", redirect_o); end
      checks++; if (redirect_pc_o !== 32'h120) begin errors++; $display("FAIL beq_pc got %0h exp 120", redirect_pc_o); end
      checks++; if (br_taken_o !== 1'b1) begin errors++; $display("FAIL beq_taken got %0h exp 1", br_taken_o); end
      checks++; if (mispredict_cnt_o !== 3'd1) begin errors++; $display("FAIL beq_cnt got %0d exp 1", mispredict_cnt_o); end
      idle(); step();
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL beq_pulse got %0h exp 0", redirect_o); end
   endtask

   task automatic test_signed_unsigned();
      set_ex(7'b1100011, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
      step();
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL blt_redirect got %0h exp 0", redirect_o); end
      checks++; if (br_taken_o !== 1'b1) begin errors++; $display("FAIL blt_taken got %0h exp 1", br_taken_o); end
      checks++; if (mispredict_cnt_o !== 3'd1) begin errors++; $display("FAIL blt_cnt got %0d exp 1", mispredict_cnt_o); end
      set_ex(7'b1100011, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
      step();
      checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL bltu_redirect got %0h exp 1", redirect_o); end
      checks++; if (redirect_pc_o !== 32'h204) begin errors++; $display("FAIL bltu_pc got %0h exp 204", redirect_pc_o); end
      checks++; if (br_taken_o !== 1'b0) begin errors++; $display("FAIL bltu_taken got %0h exp 0", br_taken_o); end
      checks++; if (mispredict_cnt_o !== 3'd2) begin errors++; $display("FAIL bltu_cnt got %0d exp 2", mispredict_cnt_o); end
      idle(); step();
   endtask

   task automatic test_jalr_shadow();
      set_ex(7'b1100111, 3'b000, 32'h1003, 32'h0, 32'h280, 32'h10, 1'b0);
      step();
      checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL jalr_redirect got %0h exp 1", redirect_o); end
      checks++; if (redirect_pc_o !== 32'h1012) begin errors++; $display("FAIL jalr_pc got %0h exp 1012", redirect_pc_o); end
      checks++; if (br_taken_o !== 1'b1) begin errors++; $display("FAIL jalr_taken got %0h exp 1", br_taken_o); end
      checks++; if (mispredict_cnt_o !== 3'd2) begin errors++; $display("FAIL jalr_cnt got %0d exp 2", mispredict_cnt_o); end
      set_ex(7'b1100011, 3'b001, 32'd1, 32'd2, 32'h300, 32'h40, 1'b0);
      step();
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL squash_redirect got %0h exp 0", redirect_o); end
      checks++; if (mispredict_cnt_o !== 3'd2) begin errors++; $display("FAIL squash_cnt got %0d exp 2", mispredict_cnt_o); end
      step();
      checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL after_squash_redirect got %0h exp 1", redirect_o); end
      checks++; if (redirect_pc_o !== 32'h340) begin errors++; $display("FAIL after_squash_pc got %0h exp 340", redirect_pc_o); end
      checks++; if (mispredict_cnt_o !== 3'd3) begin errors++; $display("FAIL after_squash_cnt got %0d exp 3", mispredict_cnt_o); end
      idle(); step();
   endtask

   task automatic test_stall();
      set_ex(7'b1100011, 3'b000, 32'd7, 32'd7, 32'h400, 32'h8, 1'b0);
      stall_i = 1'b1;
      step(); step();
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL stall_redirect got %0h exp 0", redirect_o); end
      checks++; if (mispredict_cnt_o !== 3'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", mispredict_cnt_o); end
      checks++; if (redirect_pc_o !== 32'h340) begin errors++; $display("FAIL stall_pc_hold got %0h exp 340", redirect_pc_o); end
      stall_i = 1'b0;
      step();
      checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL release_redirect got %0h exp 1", redirect_o); end
      checks++; if (redirect_pc_o !== 32'h408) begin errors++; $display("FAIL release_pc got %0h exp 408", redirect_pc_o); end
      checks++; if (mispredict_cnt_o !== 3'd4) begin errors++; $display("FAIL release_cnt got %0d exp 4", mispredict_cnt_o); end
      stall_i = 1'b1;
      step();
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL stall_shadow_redirect got %0h exp 0", redirect_o); end
      stall_i = 1'b0;
      step();
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL shadow_held_redirect got %0h exp 0", redirect_o); end
      checks++; if (mispredict_cnt_o !== 3'd4) begin errors++; $display("FAIL shadow_held_cnt got %0d exp 4", mispredict_cnt_o); end
      step();
      checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL shadow_clear_redirect got %0h exp 1", redirect_o); end
      checks++; if (mispredict_cnt_o !== 3'd5) begin errors++; $display("FAIL shadow_clear_cnt got %0d exp 5", mispredict_cnt_o); end
      idle(); step();
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL stall_pulse got %0h exp 0", redirect_o); end
   endtask

   task automatic test_misc();
      set_ex(7'b0110011, 3'b000, 32'd1, 32'd1, 32'h500, 32'h8, 1'b1);
      step();
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL other_op_redirect got %0h exp 0", redirect_o); end
      set_ex(7'b1100011, 3'b010, 32'd1, 32'd1, 32'h500, 32'h8, 1'b1);
      step();
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL illegal_redirect got %0h exp 0", redirect_o); end
      checks++; if (mispredict_cnt_o !== 3'd5) begin errors++; $display("FAIL illegal_cnt got %0d exp 5", mispredict_cnt_o); end
      set_ex(7'b1101111, 3'b000, 32'd0, 32'd0, 32'h600, 32'hFFFF_FFF8, 1'b0);
      step();
      checks++; if (redirect_pc_o !== 32'h5F8) begin errors++; $display("FAIL jal_pc got %0h exp 5f8", redirect_pc_o); end
      checks++; if (mispredict_cnt_o !== 3'd5) begin errors++; $display("FAIL jal_cnt got %0d exp 5", mispredict_cnt_o); end
      idle(); step();
      set_ex(7'b1100011, 3'b101, 32'd3, 32'd3, 32'hFFFF_FFF0, 32'h20, 1'b0);
      step();
      checks++; if (redirect_pc_o !== 32'h10) begin errors++; $display("FAIL wrap_pc got %0h exp 10", redirect_pc_o); end
      idle(); step();
      set_ex(7'b1100011, 3'b111, 32'd2, 32'd3, 32'hFFFF_FFFC, 32'h20, 1'b1);
      step();
      checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL wrap_fall_pc got %0h exp 0", redirect_pc_o); end
      idle(); step();
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 9; i++) begin
         set_ex(7'b1100011, 3'b000, 32'd9, 32'd9, 32'h700, 32'h4, 1'b0);
         step();
         idle(); step();
         if (i == 1) begin
            checks++; if (mispredict_cnt_o !== 3'd7) begin errors++; $display("FAIL sat_reach got %0d exp 7", mispredict_cnt_o); end
         end
      end
      checks++; if (mispredict_cnt_o !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d exp 7", mispredict_cnt_o); end
   endtask

   task automatic test_bht();
      reset_i = 1'b1; #2; reset_i = 1'b0; step();
      if_pc_i = 32'h40;
      #1;
      checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL bht_init got %0h exp 0", pred_taken_o); end
`ifdef BRU_BHT_EN
      set_ex(7'b1100011, 3'b000, 32'd1, 32'd1, 32'h40, 32'h10, 1'b1);
      @(negedge clk_i);
      checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL bht_collision got %0h exp 0", pred_taken_o); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL bht_taken_%0d got %0h exp 1", i, pred_taken_o); end
      end
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL bht_no_redirect got %0h exp 0", redirect_o); end
      set_ex(7'b1100011, 3'b001, 32'd1, 32'd1, 32'h40, 32'h10, 1'b0);
      step();
      checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL bht_nt_1 got %0h exp 1", pred_taken_o); end
      step();
      checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL bht_nt_2 got %0h exp 0", pred_taken_o); end
      if_pc_i = 32'h44; #1;
      checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL bht_neighbor got %0h exp 0", pred_taken_o); end
      set_ex(7'b1100011, 3'b000, 32'd1, 32'd1, 32'h40, 32'h10, 1'b1);
      stall_i = 1'b1; if_pc_i = 32'h40;
      step(); step();
      checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL bht_stall_hold got %0h exp 0", pred_taken_o); end
      stall_i = 1'b0;
`endif
      idle(); step();
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 3; i++) begin
         set_ex(7'b1100011, 3'b000, 32'd4, 32'd4, 32'h40, 32'h80, 1'b0);
         step();
         if (i < 2) begin idle(); step(); end
      end
      checks++; if (mispredict_cnt_o !== 3'd3) begin errors++; $display("FAIL mid_cnt got %0d exp 3", mispredict_cnt_o); end
      checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL mid_redirect got %0h exp 1", redirect_o); end
`ifdef BRU_BHT_EN
      if_pc_i = 32'h40; #1;
      checks++; if (pred_taken_o !== 1'b1) begin errors++; $display("FAIL mid_bht_trained got %0h exp 1", pred_taken_o); end
`endif
      reset_i = 1'b1;
      #1;
      checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL rstmid_redirect got %0h exp 0", redirect_o); end
      checks++; if (mispredict_cnt_o !== 3'd0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", mispredict_cnt_o); end
      step();
      for (int i = 0; i < 64; i++) begin
         if_pc_i = 32'(i * 4); #1;
         checks++; if (pred_taken_o !== 1'b0) begin errors++; $display("FAIL rstmid_bht_%0d got %0h exp 0", i, pred_taken_o); end
      end
      reset_i = 1'b0; idle(); step();
      checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rstmid_pc got %0h exp 0", redirect_pc_o); end
   endtask

   initial begin
      test_reset();
      test_beq();
      test_signed_unsigned();
      test_jalr_shadow();
      test_stall();
      test_misc();
      test_saturate();
      test_bht();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
